// File: rtl/cache_mem_bridge_pkg.sv
// Shared definitions for the cache-to-memory word bridge.
// Bridge FSM state encodings.
package cache_mem_bridge_pkg;

    typedef enum logic [1:0] {
        BR_IDLE = 2'd0,
        BR_BUSY = 2'd1,
        BR_DONE = 2'd2
    } br_state_e;

endpackage

// File: rtl/cache_mem_bridge.sv
// Word-serial bridge between the cache RAM port and the backing word memory.
// One mem_req/mem_ack handshake per cache word transaction; loads fill block lanes.
module cache_mem_bridge
    import cache_mem_bridge_pkg::*;
#(
    parameter int OFFSET_WIDTH = 3,
    parameter int ADDR_WIDTH   = 30,
    parameter int DATA_WIDTH   = 32,
    parameter int BLOCK_SIZE   = 1 << OFFSET_WIDTH,
    parameter int BLOCK_WIDTH  = DATA_WIDTH * BLOCK_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ram_en,
    input  logic                   ram_write,
    input  logic [ADDR_WIDTH-1:0]  ram_addr,
    input  logic [BLOCK_WIDTH-1:0] dc_data_wb,
    output logic                   ram_ready,
    output logic [BLOCK_WIDTH-1:0] block_from_ram,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic                   mem_ack,
    input  logic [DATA_WIDTH-1:0]  mem_rdata
);

    br_state_e               state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BLOCK_WIDTH-1:0]  block_q, block_d;

    logic [OFFSET_WIDTH-1:0] req_lane;
    logic [OFFSET_WIDTH-1:0] lat_lane;

    assign req_lane = ram_addr[OFFSET_WIDTH-1:0];
    assign lat_lane = addr_q[OFFSET_WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        block_d   = block_q;
        mem_req   = 1'b0;
        ram_ready = 1'b0;
        case (state_q)
            BR_IDLE: begin
                if (ram_en) begin
                    addr_d  = ram_addr;
                    we_d    = ram_write;
                    wdata_d = dc_data_wb[int'(req_lane)*DATA_WIDTH +: DATA_WIDTH];
                    state_d = BR_BUSY;
                end
            end
            BR_BUSY: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    if (!we_q) begin
                        block_d[int'(lat_lane)*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
                    end
                    state_d = BR_DONE;
                end
            end
            BR_DONE: begin
                // The cache advances its word counter on this edge.
                ram_ready = 1'b1;
                state_d   = BR_IDLE;
            end
            default: state_d = BR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BR_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            block_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            block_q <= block_d;
        end
    end

    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign block_from_ram = block_q;

endmodule
